mole_scheduler: RTL and testbench

Game-sequencing controller for the whack-a-mole datapath. It owns the 8-bit LFSR random generator: it seeds it through the generator's load/seed inputs and reads its output. It turns the random values into a timed sequence of mole appearances across NUM_HOLES holes, and scores debounced player hits against the active mole. It sits between the tick divider and button debouncers on one side and the LED/score display logic on the other.

---
 rtl/mole_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: game sequencer for the whack-a-mole datapath.
// Seeds the external 8-bit LFSR, picks a random hole per round, times the
// up and gap windows from the tick timebase, and scores player presses.
// Optional feature: define MOLE_SPEEDUP_EN to shrink the up window by one
// tick after every 4th correct hit, never below MIN_UP_TICKS.
module mole_scheduler #(
  parameter int unsigned NUM_HOLES    = 9,
  parameter int unsigned HOLE_W       = 4,
  parameter int unsigned UP_TICKS     = 20,
  parameter int unsigned GAP_TICKS    = 8,
  parameter int unsigned ROUNDS       = 30,
  parameter int unsigned MIN_UP_TICKS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_HOLES-1:0] hit,
  input  logic [7:0]           rand_num,
  output logic                 lfsr_load,
  output logic [7:0]           lfsr_seed,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           hit_cnt,
  output logic [7:0]           miss_cnt,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEED = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_PICK = 3'd3;
  localparam logic [2:0] S_UP   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [HOLE_W-1:0] LAST_HOLE = HOLE_W'(NUM_HOLES - 1);
  localparam logic [4:0]        MAX_RETRY = 5'd16;

  logic [2:0]           r_state;
  logic [7:0]           r_seed_cnt;
  logic [HOLE_W-1:0]    r_prev_hole;
  logic [7:0]           r_tick_cnt;
  logic [7:0]           r_round_cnt;
  logic [4:0]           r_retry_cnt;
  logic [NUM_HOLES-1:0] r_mole;
  logic [7:0]           r_hit_cnt;
  logic [7:0]           r_miss_cnt;
  logic                 r_hit_pulse;
  logic                 r_miss_pulse;
  logic                 r_lfsr_load;
  logic [7:0]           r_lfsr_seed;

  logic [HOLE_W-1:0]    w_idx;
  logic                 w_idx_ok;
  logic [HOLE_W-1:0]    w_force_idx;
  logic                 w_accept;
  logic [HOLE_W-1:0]    w_pick_idx;
  logic [NUM_HOLES-1:0] w_hole_bit;
  logic                 w_hit_right;
  logic                 w_hit_wrong;
  logic [7:0]           w_up_win;
  logic                 w_unused;

  // Random index candidate and the forced fallback after too many rejects
  always_comb begin
    w_idx       = rand_num[HOLE_W-1:0];
    w_idx_ok    = (32'(w_idx) < NUM_HOLES) && (w_idx != r_prev_hole);
    w_force_idx = (r_prev_hole == LAST_HOLE) ? '0 : r_prev_hole + 1'b1;
    w_accept    = w_idx_ok || (r_retry_cnt == MAX_RETRY);
    w_pick_idx  = w_idx_ok ? w_idx : w_force_idx;
    w_hole_bit  = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_pick_idx;
    w_hit_right = |(hit & r_mole);
    w_hit_wrong = |(hit & ~r_mole);
  end

`ifdef MOLE_SPEEDUP_EN
  logic [7:0] r_up_win;
  logic [1:0] r_hit_mod;
  logic       w_game_start;
  logic       w_hit_event;

  assign w_game_start = start && !stop && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hit_event  = !stop && (r_state == S_UP) && w_hit_right;
  assign w_up_win     = r_up_win;
  assign w_unused     = ^rand_num;

  // Up-window shrink: one tick shorter after every 4th correct hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up_win  <= 8'(UP_TICKS);
      r_hit_mod <= '0;
    end else if (w_game_start) begin
      r_up_win  <= 8'(UP_TICKS);
      r_hit_mod <= '0;
    end else if (w_hit_event) begin
      r_hit_mod <= r_hit_mod + 2'd1;
      if ((r_hit_mod == 2'd3) && (r_up_win > 8'(MIN_UP_TICKS))) begin
        r_up_win <= r_up_win - 8'd1;
      end
    end
  end
`else
  assign w_up_win = 8'(UP_TICKS);
  assign w_unused = ^{rand_num, 8'(MIN_UP_TICKS)};
`endif

  // Free-running seed source, sampled when a game starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed_cnt <= '0;
    end else begin
      r_seed_cnt <= r_seed_cnt + 8'd1;
    end
  end

  // Game FSM with registered mole, scores, strobes and LFSR seeding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev_hole  <= '0;
      r_tick_cnt   <= '0;
      r_round_cnt  <= '0;
      r_retry_cnt  <= '0;
      r_mole       <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_lfsr_load  <= 1'b0;
      r_lfsr_seed  <= '0;
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_lfsr_load  <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_mole  <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_mole <= '0;
            if (start) begin
              r_hit_cnt   <= '0;
              r_miss_cnt  <= '0;
              r_round_cnt <= '0;
              // load strobe is registered so it is high exactly during SEED
              r_lfsr_load <= 1'b1;
              r_lfsr_seed <= (r_seed_cnt == 8'd0) ? 8'hA5 : r_seed_cnt;
              r_state     <= S_SEED;
            end
          end
          S_SEED: begin
            r_tick_cnt <= '0;
            r_state    <= S_GAP;
          end
          S_GAP: begin
            if (tick) begin
              if (r_tick_cnt == 8'(GAP_TICKS - 1)) begin
                r_tick_cnt  <= '0;
                r_retry_cnt <= '0;
                r_state     <= (r_round_cnt == 8'(ROUNDS)) ? S_DONE : S_PICK;
              end else begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
              end
            end
          end
          S_PICK: begin
            if (w_accept) begin
              r_mole      <= w_hole_bit;
              r_prev_hole <= w_pick_idx;
              r_round_cnt <= r_round_cnt + 8'd1;
              r_tick_cnt  <= '0;
              r_retry_cnt <= '0;
              r_state     <= S_UP;
            end else begin
              r_retry_cnt <= r_retry_cnt + 5'd1;
            end
          end
          S_UP: begin
            if (w_hit_right) begin
              r_hit_cnt   <= (r_hit_cnt == 8'hFF) ? r_hit_cnt : r_hit_cnt + 8'd1;
              r_hit_pulse <= 1'b1;
              r_mole      <= '0;
              r_tick_cnt  <= '0;
              r_state     <= S_GAP;
            end else if (w_hit_wrong) begin
              r_miss_cnt   <= (r_miss_cnt == 8'hFF) ? r_miss_cnt : r_miss_cnt + 8'd1;
              r_miss_pulse <= 1'b1;
            end else if (tick) begin
              if (r_tick_cnt == w_up_win - 8'd1) begin
                r_miss_cnt   <= (r_miss_cnt == 8'hFF) ? r_miss_cnt : r_miss_cnt + 8'd1;
                r_miss_pulse <= 1'b1;
                r_mole       <= '0;
                r_tick_cnt   <= '0;
                r_state      <= S_GAP;
              end else begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_mole  <= '0;
          end
        endcase
      end
    end
  end

  assign lfsr_load  = r_lfsr_load;
  assign lfsr_seed  = r_lfsr_seed;
  assign mole       = r_mole;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed testbench for mole_scheduler: a main instance (UP=4, GAP=2)
// and a short-game instance (ROUNDS=2, GAP=1, UP=1) share the inputs.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [8:0] hit = '0;
  logic [7:0] rand_num = '0;

  logic       lfsr_load, hit_pulse, miss_pulse, busy, done;
  logic [7:0] lfsr_seed, hit_cnt, miss_cnt;
  logic [8:0] mole;

  logic       s_load, s_hp, s_mp, s_busy, s_done;
  logic [7:0] s_seed, s_hit, s_miss;
  logic [8:0] s_mole;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] tb_seed;

  mole_scheduler #(
    .NUM_HOLES(9), .HOLE_W(4), .UP_TICKS(4), .GAP_TICKS(2), .ROUNDS(30), .MIN_UP_TICKS(2)
  ) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .hit(hit),
    .rand_num(rand_num), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .mole(mole),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .busy(busy), .done(done)
  );

  mole_scheduler #(
    .NUM_HOLES(9), .HOLE_W(4), .UP_TICKS(1), .GAP_TICKS(1), .ROUNDS(2), .MIN_UP_TICKS(1)
  ) u_small (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .hit(hit),
    .rand_num(rand_num), .lfsr_load(s_load), .lfsr_seed(s_seed), .mole(s_mole),
    .hit_cnt(s_hit), .miss_cnt(s_miss), .hit_pulse(s_hp), .miss_pulse(s_mp),
    .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  // Reference seed counter: cycles since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) tb_seed <= '0;
    else     tb_seed <= tb_seed + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; hit = '0; rand_num = '0;
    step();
    n_total++; if ({lfsr_load, hit_pulse, miss_pulse, busy, done} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {lfsr_load, hit_pulse, miss_pulse, busy, done}); else n_pass++;
    n_total++; if ({lfsr_seed, hit_cnt, miss_cnt, mole} !== 33'h0) $display("FAIL reset_values: got %h expected 0", {lfsr_seed, hit_cnt, miss_cnt, mole}); else n_pass++;
  endtask

  task automatic test_seed_zero();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (lfsr_load !== 1'b1) $display("FAIL seed_load: got %b expected 1", lfsr_load); else n_pass++;
    n_total++; if (lfsr_seed !== 8'hA5) $display("FAIL seed_a5: got %h expected a5", lfsr_seed); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL seed_busy: got %b expected 1", busy); else n_pass++;
    step();
    n_total++; if ({lfsr_load, lfsr_seed} !== {1'b0, 8'hA5}) $display("FAIL gap_load_seed: got %h expected 0a5", {lfsr_load, lfsr_seed}); else n_pass++;
  endtask

  task automatic test_pick_force();
    int n;
    rand_num = 8'h0F;
    tick_pulse();
    tick_pulse();
    n_total++; if (mole !== 9'h000) $display("FAIL pick_entry_mole: got %h expected 000", mole); else n_pass++;
    n = 0;
    while (mole === 9'h000 && n < 25) begin
      step();
      n++;
    end
    n_total++; if (mole !== 9'h002) $display("FAIL pick_force_mole: got %h expected 002", mole); else n_pass++;
    n_total++; if (n < 16 || n > 17) $display("FAIL pick_force_cycles: got %0d expected 16..17", n); else n_pass++;
  endtask

  task automatic test_hit_with_tick();
    hit = 9'h002; tick = 1'b1;
    step();
    hit = '0; tick = 1'b0;
    n_total++; if ({hit_cnt, miss_cnt} !== 16'h0100) $display("FAIL hit_tick_counts: got %h expected 0100", {hit_cnt, miss_cnt}); else n_pass++;
    n_total++; if ({hit_pulse, miss_pulse} !== 2'b10) $display("FAIL hit_tick_pulses: got %b expected 10", {hit_pulse, miss_pulse}); else n_pass++;
    n_total++; if (mole !== 9'h000) $display("FAIL hit_tick_mole: got %h expected 000", mole); else n_pass++;
    step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL hit_pulse_width: got %b expected 0", hit_pulse); else n_pass++;
  endtask

  task automatic test_pick_direct();
    rand_num = 8'h03;
    tick_pulse();
    tick_pulse();
    step();
    n_total++; if (mole !== 9'h008) $display("FAIL pick_direct_mole: got %h expected 008", mole); else n_pass++;
  endtask

  task automatic test_wrong_then_timeout();
    hit = 9'h020;
    step();
    hit = '0;
    n_total++; if ({miss_cnt, miss_pulse} !== {8'd1, 1'b1}) $display("FAIL wrong_miss: got %h expected 003", {miss_cnt, miss_pulse}); else n_pass++;
    n_total++; if (mole !== 9'h008) $display("FAIL wrong_mole_kept: got %h expected 008", mole); else n_pass++;
    step();
    n_total++; if (miss_pulse !== 1'b0) $display("FAIL miss_pulse_width: got %b expected 0", miss_pulse); else n_pass++;
    tick_pulse(); tick_pulse(); tick_pulse();
    n_total++; if ({mole, miss_cnt} !== {9'h008, 8'd1}) $display("FAIL up_before_last_tick: got %h expected 00801", {mole, miss_cnt}); else n_pass++;
    tick_pulse();
    n_total++; if ({miss_cnt, miss_pulse} !== {8'd2, 1'b1}) $display("FAIL timeout_miss: got %h expected 005", {miss_cnt, miss_pulse}); else n_pass++;
    n_total++; if (mole !== 9'h000) $display("FAIL timeout_mole: got %h expected 000", mole); else n_pass++;
  endtask

  task automatic test_multi_wrong();
    rand_num = 8'hF7;
    tick_pulse();
    tick_pulse();
    step();
    n_total++; if (mole !== 9'h080) $display("FAIL multi_pick_mole: got %h expected 080", mole); else n_pass++;
    hit = 9'h005;
    step();
    hit = '0;
    n_total++; if ({hit_cnt, miss_cnt} !== 16'h0103) $display("FAIL multi_wrong_counts: got %h expected 0103", {hit_cnt, miss_cnt}); else n_pass++;
  endtask

  task automatic test_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_total++; if ({mole, busy, done} !== 11'h0) $display("FAIL stop_state: got %h expected 000", {mole, busy, done}); else n_pass++;
    n_total++; if ({hit_cnt, miss_cnt} !== 16'h0103) $display("FAIL stop_counts_hold: got %h expected 0103", {hit_cnt, miss_cnt}); else n_pass++;
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    n_total++; if ({busy, lfsr_load} !== 2'b00) $display("FAIL stop_over_start: got %b expected 00", {busy, lfsr_load}); else n_pass++;
  endtask

  task automatic test_restart_and_rst();
    logic [7:0] exp_seed;
    exp_seed = (tb_seed == 8'd0) ? 8'hA5 : tb_seed;
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if ({lfsr_load, lfsr_seed} !== {1'b1, exp_seed}) $display("FAIL restart_seed: got %h expected %h", {lfsr_load, lfsr_seed}, {1'b1, exp_seed}); else n_pass++;
    n_total++; if ({hit_cnt, miss_cnt} !== 16'h0) $display("FAIL restart_clear: got %h expected 0000", {hit_cnt, miss_cnt}); else n_pass++;
    step();
    rand_num = 8'h04;
    tick_pulse();
    tick_pulse();
    step();
    n_total++; if (mole !== 9'h010) $display("FAIL restart_mole: got %h expected 010", mole); else n_pass++;
    hit = 9'h001;
    step();
    hit = '0;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({mole, hit_cnt, miss_cnt, busy, done, lfsr_load, lfsr_seed, miss_pulse} !== 39'h0) $display("FAIL rst_midgame: got %h expected 0", {mole, hit_cnt, miss_cnt, busy, done, lfsr_load, lfsr_seed, miss_pulse}); else n_pass++;
  endtask

  task automatic test_short_game();
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rand_num = 8'h02;
    tick_pulse();
    step();
    n_total++; if (s_mole !== 9'h004) $display("FAIL short_mole1: got %h expected 004", s_mole); else n_pass++;
    tick_pulse();
    n_total++; if ({s_mole, s_miss, s_mp} !== {9'h000, 8'd1, 1'b1}) $display("FAIL short_timeout1: got %h expected %h", {s_mole, s_miss, s_mp}, {9'h000, 8'd1, 1'b1}); else n_pass++;
    rand_num = 8'h05;
    tick_pulse();
    step();
    n_total++; if (s_mole !== 9'h020) $display("FAIL short_mole2: got %h expected 020", s_mole); else n_pass++;
    tick_pulse();
    n_total++; if ({s_mole, s_miss} !== {9'h000, 8'd2}) $display("FAIL short_timeout2: got %h expected %h", {s_mole, s_miss}, {9'h000, 8'd2}); else n_pass++;
    tick_pulse();
    n_total++; if ({s_done, s_busy, s_mole} !== {2'b10, 9'h000}) $display("FAIL short_done: got %h expected %h", {s_done, s_busy, s_mole}, {2'b10, 9'h000}); else n_pass++;
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if ({s_hit, s_miss, s_busy, s_done} !== {16'h0, 2'b10}) $display("FAIL short_restart: got %h expected %h", {s_hit, s_miss, s_busy, s_done}, {16'h0, 2'b10}); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seed_zero();
    test_pick_force();
    test_hit_with_tick();
    test_pick_direct();
    test_wrong_then_timeout();
    test_multi_wrong();
    test_stop();
    test_restart_and_rst();
    test_short_game();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
